regfile_wb_arbiter: RTL and testbench

//  Shares the single write port of the decode-stage register file between NREQ writeback sources (ALU, load, vector unit).

---
 rtl/regfile_wb_arbiter_pkg.sv | 18 +
 rtl/regfile_wb_arbiter_if.sv | 31 +++
 rtl/regfile_wb_arbiter_rr.sv | 52 +++++
 rtl/regfile_wb_arbiter.sv | 104 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared sizes and types for the regfile writeback arbiter.
// Revision: 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int NREQ  = 3;
    localparam int NREGS = 16;
    localparam int AW    = $clog2(NREGS);
    localparam int DW    = 16;

    typedef logic [AW-1:0] reg_idx_t;
    typedef logic [DW-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter_if
// Brief   : Per-source writeback valid/ready bus into the regfile arbiter.
// Revision: 1.0  initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int NREQ = regfile_pkg::NREQ
);

    logic [NREQ-1:0]       req_valid;
    regfile_pkg::reg_idx_t  req_dest [NREQ];
    regfile_pkg::reg_data_t req_data [NREQ];
    logic [NREQ-1:0]       req_ready;

    modport master (
        output req_valid,
        output req_dest,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_dest,
        input  req_data,
        output req_ready
    );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin one-hot arbiter; search starts at the stored pointer.
// Revision: 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic [N-1:0]  valid,
    input  wire logic          advance,
    output logic      [N-1:0]  grant,
    output logic      [PW-1:0] ptr
);

    logic [PW-1:0] rPtr;
    logic [PW-1:0] wIdx;
    logic [PW-1:0] wWin;
    logic [PW-1:0] wNext;
    logic          wFound;

    always_comb begin
        grant  = '0;
        wIdx   = '0;
        wWin   = '0;
        wFound = 1'b0;
        for (int k = 0; k < N; k++) begin
            wIdx = PW'((int'(rPtr) + k) % N);
            if (!wFound && valid[wIdx]) begin
                grant[wIdx] = 1'b1;
                wWin        = wIdx;
                wFound      = 1'b1;
            end
        end
        wNext = PW'((int'(wWin) + 1) % N);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rPtr <= '0;
        end else if (advance && wFound) begin
            rPtr <= wNext;
        end
    end

    assign ptr = rPtr;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter
// Brief   : Round-robin share of the regfile write port plus busy scoreboard.
// Revision: 1.0  initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = regfile_pkg::NREQ
) (
    input  wire logic             clk,
    input  wire logic             rst,
    regfile_wb_arbiter_if.slave   wb,
    input  wire logic             rsv_valid,
    input  wire reg_idx_t         rsv_dest,
    output logic                  rsv_ok,
    input  wire reg_idx_t         rd_src1,
    input  wire reg_idx_t         rd_src2,
    output logic                  rd_hazard,
    output logic                  rf_we,
    output reg_idx_t              rf_dest,
    output reg_data_t             rf_wdata,
    output logic [NREGS-1:0]      busy_vec,
    output logic                  err_unrsv
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  wGrant;
    logic [NREQ-1:0]  wReady;
    logic [PW-1:0]    wPtr;
    logic             wAny;
    reg_idx_t         wDest;
    reg_data_t        wData;
    logic             wRsvOk;

    logic [NREGS-1:0] rBusy;
    logic             rErr;
    logic             rWe;
    reg_idx_t         rDest;
    reg_data_t        rData;

    rr_arbiter #(.N(NREQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .valid   (wb.req_valid),
        .advance (wAny),
        .grant   (wGrant),
        .ptr     (wPtr)
    );

    // Ready is masked asynchronously so no transfer can be seen during reset.
    assign wReady       = wGrant & {NREQ{rst}};
    assign wb.req_ready = wReady;

    always_comb begin
        wAny  = |wReady;
        wDest = '0;
        wData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (wReady[i]) begin
                wDest = wb.req_dest[i];
                wData = wb.req_data[i];
            end
        end
    end

    // A reservation colliding with this cycle's clear is refused; the clear wins.
    assign wRsvOk    = rsv_valid && !rBusy[rsv_dest] && !(wAny && (wDest == rsv_dest));
    assign rsv_ok    = wRsvOk;
    assign rd_hazard = rBusy[rd_src1] | rBusy[rd_src2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rBusy <= '0;
            rErr  <= 1'b0;
            rWe   <= 1'b0;
            rDest <= '0;
            rData <= '0;
        end else begin
            rWe <= wAny;
            if (wAny) begin
                rBusy[wDest] <= 1'b0;
                rDest        <= wDest;
                rData        <= wData;
                if (!rBusy[wDest]) begin
                    rErr <= 1'b1;
                end
            end
            if (wRsvOk) begin
                rBusy[rsv_dest] <= 1'b1;
            end
        end
    end

    assign rf_we     = rWe;
    assign rf_dest   = rDest;
    assign rf_wdata  = rData;
    assign busy_vec  = rBusy;
    assign err_unrsv = rErr;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_wb_arbiter
// Brief   : Directed and random checks of the arbiter against a scoreboard model.
// Revision: 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NREQ(N)) wb ();

    logic             rsv_valid;
    reg_idx_t         rsv_dest;
    logic             rsv_ok;
    reg_idx_t         rd_src1;
    reg_idx_t         rd_src2;
    logic             rd_hazard;
    logic             rf_we;
    reg_idx_t         rf_dest;
    reg_data_t        rf_wdata;
    logic [NREGS-1:0] busy_vec;
    logic             err_unrsv;

    regfile_wb_arbiter #(.NREQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb        (wb),
        .rsv_valid (rsv_valid),
        .rsv_dest  (rsv_dest),
        .rsv_ok    (rsv_ok),
        .rd_src1   (rd_src1),
        .rd_src2   (rd_src2),
        .rd_hazard (rd_hazard),
        .rf_we     (rf_we),
        .rf_dest   (rf_dest),
        .rf_wdata  (rf_wdata),
        .busy_vec  (busy_vec),
        .err_unrsv (err_unrsv)
    );

    int vecCount = 0;
    int errCount = 0;

    // Reference state: which registers are reserved, whose turn it is, last write.
    logic [NREGS-1:0] mBusy;
    int               mPtr;
    logic             mWe;
    int               mDest;
    int               mData;
    logic             mErr;
    int               lastGrant;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pickWinner();
        for (int k = 0; k < N; k++) begin
            if (wb.req_valid[(mPtr + k) % N]) return (mPtr + k) % N;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mBusy     = '0;
        mPtr      = 0;
        mWe       = 1'b0;
        mDest     = 0;
        mData     = 0;
        mErr      = 1'b0;
        lastGrant = -1;
    endtask

    task automatic cycle();
        int          g;
        logic        ok;
        logic [N-1:0] expReady;
        #1;
        g        = pickWinner();
        expReady = '0;
        if (g >= 0) expReady[g] = 1'b1;
        ok = rsv_valid && !mBusy[rsv_dest] && !(g >= 0 && wb.req_dest[g] == rsv_dest);
        checkEq("req_ready", 32'(wb.req_ready), 32'(expReady));
        checkEq("rsv_ok", 32'(rsv_ok), 32'(ok));
        checkEq("rd_hazard", 32'(rd_hazard), 32'(mBusy[rd_src1] | mBusy[rd_src2]));
        @(posedge clk);
        if (g >= 0) begin
            if (!mBusy[wb.req_dest[g]]) mErr = 1'b1;
            mBusy[wb.req_dest[g]] = 1'b0;
            mWe   = 1'b1;
            mDest = int'(wb.req_dest[g]);
            mData = int'(wb.req_data[g]);
            mPtr  = (g + 1) % N;
        end else begin
            mWe = 1'b0;
        end
        if (ok) mBusy[rsv_dest] = 1'b1;
        lastGrant = g;
        #1;
        checkEq("rf_we", 32'(rf_we), 32'(mWe));
        checkEq("rf_dest", 32'(rf_dest), 32'(mDest));
        checkEq("rf_wdata", 32'(rf_wdata), 32'(mData));
        checkEq("busy_vec", 32'(busy_vec), 32'(mBusy));
        checkEq("err_unrsv", 32'(err_unrsv), 32'(mErr));
    endtask

    task automatic doReset(input int offset);
        #(offset);
        rst = 1'b0;
        #1;
        modelReset();
        checkEq("rst_ready", 32'(wb.req_ready), 0);
        checkEq("rst_rf_we", 32'(rf_we), 0);
        checkEq("rst_rf_dest", 32'(rf_dest), 0);
        checkEq("rst_rf_wdata", 32'(rf_wdata), 0);
        checkEq("rst_busy", 32'(busy_vec), 0);
        checkEq("rst_err", 32'(err_unrsv), 0);
        wb.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic reg_idx_t pickDest();
        int base;
        base = int'($urandom_range(0, NREGS - 1));
        if (mBusy != '0 && $urandom_range(0, 3) != 0) begin
            for (int k = 0; k < NREGS; k++) begin
                if (mBusy[(base + k) % NREGS]) return reg_idx_t'((base + k) % NREGS);
            end
        end
        return reg_idx_t'(base);
    endfunction

    task automatic randomTraffic(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            if (lastGrant >= 0) wb.req_valid[lastGrant] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!wb.req_valid[i] && $urandom_range(0, 1) == 1) begin
                    wb.req_valid[i] = 1'b1;
                    wb.req_dest[i]  = pickDest();
                    wb.req_data[i]  = reg_data_t'($urandom);
                end
            end
            rsv_valid = ($urandom_range(0, 9) < 4);
            rsv_dest  = reg_idx_t'($urandom_range(0, NREGS - 1));
            rd_src1   = reg_idx_t'($urandom_range(0, NREGS - 1));
            rd_src2   = reg_idx_t'($urandom_range(0, NREGS - 1));
            cycle();
        end
    endtask

    initial begin
        wb.req_valid = '0;
        for (int i = 0; i < N; i++) begin
            wb.req_dest[i] = '0;
            wb.req_data[i] = '0;
        end
        rsv_valid = 1'b0;
        rsv_dest  = '0;
        rd_src1   = '0;
        rd_src2   = '0;
        modelReset();

        // Power-on reset, then all three sources contend from pointer 0.
        doReset(3);
        for (int i = 0; i < N; i++) begin
            wb.req_valid[i] = 1'b1;
            wb.req_dest[i]  = reg_idx_t'(i + 1);
            wb.req_data[i]  = reg_data_t'(16'h1000 + i);
        end
        for (int c = 0; c < 6; c++) begin
            cycle();
            checkEq("rr_order", 32'(lastGrant), 32'(c % 3));
            wb.req_data[lastGrant] = reg_data_t'(16'h2000 + c);
        end

        // Asynchronous reset in the middle of live traffic.
        doReset(3);
        cycle();
        checkEq("post_rst_we", 32'(rf_we), 0);

        // Reserve r5, source 1 writes it.
        rsv_valid = 1'b1;
        rsv_dest  = 4'd5;
        cycle();
        rsv_valid = 1'b0;
        wb.req_valid[1] = 1'b1;
        wb.req_dest[1]  = 4'd5;
        wb.req_data[1]  = 16'h1234;
        #1;
        checkEq("t2_ready", 32'(wb.req_ready), 32'h2);
        cycle();
        wb.req_valid[1] = 1'b0;
        checkEq("t2_rf_we", 32'(rf_we), 1);
        checkEq("t2_rf_dest", 32'(rf_dest), 5);
        checkEq("t2_rf_wdata", 32'(rf_wdata), 32'h1234);
        checkEq("t2_busy5", 32'(busy_vec[5]), 0);

        // Hazard on r3 persists until the cycle after its writeback.
        rsv_valid = 1'b1;
        rsv_dest  = 4'd3;
        cycle();
        rsv_valid = 1'b0;
        rd_src1   = 4'd3;
        rd_src2   = 4'd0;
        cycle();
        checkEq("t4_haz_set", 32'(rd_hazard), 1);
        wb.req_valid[2] = 1'b1;
        wb.req_dest[2]  = 4'd3;
        wb.req_data[2]  = 16'h0033;
        cycle();
        wb.req_valid[2] = 1'b0;
        checkEq("t4_haz_clr", 32'(rd_hazard), 0);

        // Reserve r7 in the same cycle that a grant clears r7.
        rsv_valid = 1'b1;
        rsv_dest  = 4'd7;
        cycle();
        wb.req_valid[0] = 1'b1;
        wb.req_dest[0]  = 4'd7;
        wb.req_data[0]  = 16'h0077;
        #1;
        checkEq("t5_rsv_refused", 32'(rsv_ok), 0);
        cycle();
        wb.req_valid[0] = 1'b0;
        checkEq("t5_busy7", 32'(busy_vec[7]), 0);
        #1;
        checkEq("t5_rsv_again", 32'(rsv_ok), 1);
        cycle();
        rsv_valid = 1'b0;

        // Write to a register nobody reserved.
        checkEq("t6_err_pre", 32'(err_unrsv), 0);
        wb.req_valid[0] = 1'b1;
        wb.req_dest[0]  = 4'd9;
        wb.req_data[0]  = 16'hBEEF;
        cycle();
        wb.req_valid[0] = 1'b0;
        checkEq("t6_rf_dest", 32'(rf_dest), 9);
        checkEq("t6_err", 32'(err_unrsv), 1);
        for (int c = 0; c < 3; c++) cycle();
        checkEq("t6_err_sticky", 32'(err_unrsv), 1);

        // Random traffic around a mid-run reset.
        randomTraffic(300);
        doReset(int'($urandom_range(1, 8)));
        randomTraffic(300);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
`default_nettype wire
